// File: rtl/angle_sequencer_if.sv
// Update-offer bus between angle_sequencer (master) and the shared servo driver (slave).
interface angle_sequencer_if;
  logic       upd_valid;
  logic       upd_ready;
  logic [1:0] upd_chan;
  logic [7:0] upd_angle;

  modport master (output upd_valid, output upd_chan, output upd_angle, input upd_ready);
  modport slave  (input upd_valid, input upd_chan, input upd_angle, output upd_ready);
endinterface

// File: rtl/angle_sequencer.sv
// Four-channel servo angle keeper: debounced INC/DEC keys edit the selected angle, a round-robin
// scheduler offers changed angles to the servo driver. Define ANGLE_SAT_EN to clamp at 0/ANGLE_MAX.
//
// state   | meaning
// S_IDLE  | waiting for a dirty channel
// S_OFFER | offer presented, held until the driver accepts
// S_HOLD  | one-cycle gap after acceptance
module angle_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ANGLE_MAX       = 180,
  parameter int ANGLE_INIT      = 90,
  parameter int REFRESH_CYCLES  = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_key_inc,
  input  logic              i_key_dec,
  input  logic [3:0]        i_sel,
  output logic [7:0]        o_angle1,
  output logic [7:0]        o_angle2,
  output logic [7:0]        o_angle3,
  output logic [7:0]        o_angle4,
  angle_sequencer_if.master upd_if
);
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  // An initial angle above the limit would be unreachable by editing, so it is clamped.
  localparam logic [7:0] LP_INIT = (ANGLE_INIT > ANGLE_MAX) ? 8'(ANGLE_MAX) : 8'(ANGLE_INIT);

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_HOLD} state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_sync1, r_sync2, r_db, r_db_q;
  logic [DB_W-1:0]   r_db_cnt [2];
  logic [7:0]        r_angle [4];
  logic [3:0]        r_dirty;
  logic [1:0]        r_last;
  logic              r_valid;
  logic [1:0]        r_chan;
  logic [7:0]        r_uangle;
  logic [RF_W-1:0]   r_rf_cnt;

  logic [1:0]        w_key, w_evt, w_ch, w_pick, w_idx;
  logic              w_onehot, w_inc, w_dec, w_change, w_found, w_load, w_accept, w_rf_wrap;
  logic [7:0]        w_cur, w_new;
  logic [3:0]        w_set, w_clr;

  assign w_key = {i_key_dec, i_key_inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_db     <= '0;
      r_db_q   <= '0;
      r_db_cnt <= '{default: '0};
    end else begin
      r_sync1 <= w_key;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      for (int k = 0; k < 2; k++) begin
        if (r_sync2[k] == r_db[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_db[k]     <= r_sync2[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign w_evt = r_db & ~r_db_q;

  always_comb begin
    w_onehot = 1'b0;
    w_ch     = 2'd0;
    case (i_sel)
      4'b1000: begin w_onehot = 1'b1; w_ch = 2'd0; end
      4'b0100: begin w_onehot = 1'b1; w_ch = 2'd1; end
      4'b0010: begin w_onehot = 1'b1; w_ch = 2'd2; end
      4'b0001: begin w_onehot = 1'b1; w_ch = 2'd3; end
      default: ;
    endcase
  end

  assign w_inc = w_evt[0] & ~w_evt[1] & w_onehot;
  assign w_dec = w_evt[1] & ~w_evt[0] & w_onehot;
  assign w_cur = r_angle[w_ch];

  always_comb begin
    w_new = w_cur;
`ifdef ANGLE_SAT_EN
    if (w_inc && (w_cur < 8'(ANGLE_MAX))) w_new = w_cur + 8'd1;
    else if (w_dec && (w_cur != 8'd0))    w_new = w_cur - 8'd1;
`else
    if (w_inc)      w_new = w_cur + 8'd1;
    else if (w_dec) w_new = w_cur - 8'd1;
`endif
  end

  assign w_change = (w_inc | w_dec) && (w_new != w_cur);

  // First dirty channel after the last-served one; the last-served channel is checked last.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    w_idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last + 2'(k);
      if (!w_found && r_dirty[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE:  if (w_found) begin w_load = 1'b1; w_state_nxt = S_OFFER; end
      S_OFFER: if (upd_if.upd_ready) begin w_accept = 1'b1; w_state_nxt = S_HOLD; end
      S_HOLD:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  assign w_rf_wrap = (r_rf_cnt == RF_W'(REFRESH_CYCLES - 1));
  assign w_clr     = w_load ? (4'b0001 << w_pick) : 4'b0000;
  // Setting wins over clearing so an edit to the channel being loaded is re-sent later.
  assign w_set     = (w_rf_wrap ? 4'b1111 : 4'b0000) | (w_change ? (4'b0001 << w_ch) : 4'b0000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_angle  <= '{default: LP_INIT};
      r_dirty  <= 4'b1111;
      r_last   <= 2'd3;
      r_valid  <= 1'b0;
      r_chan   <= 2'd0;
      r_uangle <= 8'd0;
      r_rf_cnt <= '0;
    end else begin
      r_rf_cnt <= w_rf_wrap ? '0 : r_rf_cnt + 1'b1;
      if (w_change) r_angle[w_ch] <= w_new;
      r_dirty <= (r_dirty & ~w_clr) | w_set;
      if (w_load) begin
        r_valid  <= 1'b1;
        r_chan   <= w_pick;
        r_uangle <= r_angle[w_pick];
        r_last   <= w_pick;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign upd_if.upd_valid = r_valid;
  assign upd_if.upd_chan  = r_chan;
  assign upd_if.upd_angle = r_uangle;
  assign o_angle1 = r_angle[0];
  assign o_angle2 = r_angle[1];
  assign o_angle3 = r_angle[2];
  assign o_angle4 = r_angle[3];
endmodule
